// File: rtl/bitty_uart_mem_pkg.sv
// Shared types and byte constants for the UART-side memory responder.
package bitty_uart_mem_pkg;

  typedef enum logic [3:0] {
    IDLE,
    GET_ADDR,
    GET_DH,
    GET_DL,
    SEND_HI,
    WAIT_HI,
    SEND_LO,
    WAIT_LO,
    SEND_ACK,
    WAIT_ACK
  } state_t;

  localparam logic [7:0] OP_LOAD  = 8'h00;
  localparam logic [7:0] OP_STORE = 8'h01;
  localparam logic [7:0] ACK_BYTE = 8'h06;

  function automatic logic is_opcode(input logic [7:0] b);
    return (b == OP_LOAD) || (b == OP_STORE);
  endfunction

endpackage

// File: rtl/bitty_uart_mem_word_mem.sv
// 16-bit word memory: one synchronous write port, one combinational read port.
// Every word clears to zero while reset is low.
module bitty_word_mem
  import bitty_uart_mem_pkg::*;
#(
  parameter int DEPTH = 32,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          wr_en,
  input  logic [AW-1:0] wr_addr,
  input  logic [15:0]   wr_data,
  input  logic [AW-1:0] rd_addr,
  output logic [15:0]   rd_data
);

  logic [15:0] words [DEPTH];

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < DEPTH; i++) words[i] <= '0;
    end else if (wr_en) begin
      words[wr_addr] <= wr_data;
    end
  end

  assign rd_data = words[rd_addr];

endmodule

// File: rtl/bitty_uart_mem.sv
// UART-side memory responder: decodes load/store frames from the CPU and
// answers with the loaded word (two bytes) or an ACK byte.
module bitty_uart_mem
  import bitty_uart_mem_pkg::*;
#(
  parameter int DEPTH   = 32,
  parameter int TIMEOUT = 50000
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [7:0] rx_data,
  input  logic       rx_done,
  input  logic       tx_done,
  output logic       tx_en,
  output logic [7:0] tx_data,
  output logic       busy,
  output logic       err
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = $clog2(TIMEOUT + 1);

  state_t         state, state_nxt;
  logic           op_store;
  logic [AW-1:0]  addr_q;
  logic [7:0]     dh_q;
  logic [7:0]     lo_q;
  logic [CW-1:0]  idle_cnt;
  logic           expired;
  logic           in_get;
  logic           take_op, take_addr, take_dh, mem_we, tx_lo_load, err_nxt;
  logic [15:0]    rd_data;

  assign in_get  = (state == GET_ADDR) || (state == GET_DH) || (state == GET_DL);
  assign expired = (idle_cnt == CW'(TIMEOUT - 1));
  assign busy    = (state != IDLE);

  bitty_word_mem #(.DEPTH(DEPTH), .AW(AW)) u_mem (
    .clk     (clk),
    .reset   (reset),
    .wr_en   (mem_we),
    .wr_addr (addr_q),
    .wr_data ({dh_q, rx_data}),
    .rd_addr (rx_data[AW-1:0]),
    .rd_data (rd_data)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= IDLE;
    else        state <= state_nxt;
  end

  // A byte arriving in the expiry cycle wins over the timeout.
  always_comb begin
    state_nxt  = state;
    take_op    = 1'b0;
    take_addr  = 1'b0;
    take_dh    = 1'b0;
    mem_we     = 1'b0;
    tx_lo_load = 1'b0;
    err_nxt    = 1'b0;
    tx_en      = 1'b0;
    case (state)
      IDLE: begin
        if (rx_done) begin
          if (is_opcode(rx_data)) begin
            take_op   = 1'b1;
            state_nxt = GET_ADDR;
          end else begin
            err_nxt = 1'b1;
          end
        end
      end
      GET_ADDR: begin
        if (rx_done) begin
          take_addr = 1'b1;
          state_nxt = op_store ? GET_DH : SEND_HI;
        end else if (expired) begin
          err_nxt   = 1'b1;
          state_nxt = IDLE;
        end
      end
      GET_DH: begin
        if (rx_done) begin
          take_dh   = 1'b1;
          state_nxt = GET_DL;
        end else if (expired) begin
          err_nxt   = 1'b1;
          state_nxt = IDLE;
        end
      end
      GET_DL: begin
        if (rx_done) begin
          mem_we    = 1'b1;
          state_nxt = SEND_ACK;
        end else if (expired) begin
          err_nxt   = 1'b1;
          state_nxt = IDLE;
        end
      end
      SEND_HI: begin
        tx_en     = 1'b1;
        state_nxt = WAIT_HI;
      end
      WAIT_HI: begin
        if (tx_done) begin
          tx_lo_load = 1'b1;
          state_nxt  = SEND_LO;
        end
      end
      SEND_LO: begin
        tx_en     = 1'b1;
        state_nxt = WAIT_LO;
      end
      WAIT_LO: if (tx_done) state_nxt = IDLE;
      SEND_ACK: begin
        tx_en     = 1'b1;
        state_nxt = WAIT_ACK;
      end
      WAIT_ACK: if (tx_done) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      op_store <= 1'b0;
      addr_q   <= '0;
      dh_q     <= '0;
      lo_q     <= '0;
      tx_data  <= '0;
      err      <= 1'b0;
      idle_cnt <= '0;
    end else begin
      err <= err_nxt;
      if (!in_get || rx_done || expired) idle_cnt <= '0;
      else                               idle_cnt <= idle_cnt + 1'b1;
      if (take_op) op_store <= (rx_data == OP_STORE);
      // The load word is captured once here; the low byte replays this sample.
      if (take_addr) begin
        addr_q <= rx_data[AW-1:0];
        if (!op_store) begin
          tx_data <= rd_data[15:8];
          lo_q    <= rd_data[7:0];
        end
      end
      if (take_dh)    dh_q    <= rx_data;
      if (mem_we)     tx_data <= ACK_BYTE;
      if (tx_lo_load) tx_data <= lo_q;
    end
  end

endmodule

// File: tb/tb_bitty_uart_mem.sv
// Directed bench: a memory/response model predicts every transmitted byte and err pulse.
module tb_bitty_uart_mem;

  localparam int DEPTH = 32;
  localparam int TO    = 20;

  logic       clk = 1'b0;
  logic       reset;
  logic [7:0] rx_data;
  logic       rx_done;
  logic       tx_done;
  logic       tx_en;
  logic [7:0] tx_data;
  logic       busy;
  logic       err;

  int compares = 0;
  int fails    = 0;

  logic [15:0] mem_m [DEPTH];
  logic [7:0]  exp_tx [$];
  int          exp_err = 0;
  logic        in_flight = 1'b0;
  logic [7:0]  held = 8'h00;

  bitty_uart_mem #(.DEPTH(DEPTH), .TIMEOUT(TO)) dut (
    .clk     (clk),
    .reset   (reset),
    .rx_data (rx_data),
    .rx_done (rx_done),
    .tx_done (tx_done),
    .tx_en   (tx_en),
    .tx_data (tx_data),
    .busy    (busy),
    .err     (err)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
    compares++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h, want 0x%0h", name, act, exp);
    end
  endtask

  // Every transmitted byte and err pulse is checked against the model queues.
  always @(negedge clk) begin
    logic [7:0] e;
    if (!reset) begin
      in_flight = 1'b0;
    end else begin
      if (tx_en) begin
        if (exp_tx.size() == 0) begin
          compares++;
          fails++;
          in_flight = 1'b0;
          $display("FAIL unexpected_tx_en: got tx_en=1 data 0x%0h, want no transmission", tx_data);
        end else begin
          e = exp_tx.pop_front();
          check("tx_byte", {8'h00, tx_data}, {8'h00, e});
          in_flight = 1'b1;
          held      = e;
        end
      end else if (in_flight) begin
        check("tx_hold", {8'h00, tx_data}, {8'h00, held});
        if (tx_done) in_flight = 1'b0;
      end
      if (err) begin
        compares++;
        if (exp_err == 0) begin
          fails++;
          $display("FAIL unexpected_err: got err=1, want err=0");
        end else begin
          exp_err--;
        end
      end
    end
  end

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic send_byte(input logic [7:0] b);
    rx_data = b;
    rx_done = 1'b1;
    tick(1);
    rx_done = 1'b0;
  endtask

  task automatic wait_tx(input string name);
    int n = 0;
    while (tx_en !== 1'b1 && n < 40) begin
      tick(1);
      n++;
    end
    compares++;
    if (tx_en !== 1'b1) begin
      fails++;
      $display("FAIL %s: got no tx_en within 40 cycles, want tx_en=1", name);
    end
  endtask

  task automatic serve_tx(input string name, input int gap);
    wait_tx(name);
    tick(1 + gap);
    tx_done = 1'b1;
    tick(1);
    tx_done = 1'b0;
  endtask

  task automatic do_store(input logic [7:0] a, input logic [15:0] d);
    mem_m[int'(a) % DEPTH] = d;
    exp_tx.push_back(8'h06);
    send_byte(8'h01);
    send_byte(a);
    send_byte(d[15:8]);
    send_byte(d[7:0]);
  endtask

  task automatic do_load(input logic [7:0] a);
    logic [15:0] w;
    w = mem_m[int'(a) % DEPTH];
    exp_tx.push_back(w[15:8]);
    exp_tx.push_back(w[7:0]);
    send_byte(8'h00);
    send_byte(a);
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_tx_en"},   {15'h0, tx_en}, 16'h0);
    check({tag, "_tx_data"}, {8'h00, tx_data}, 16'h0);
    check({tag, "_busy"},    {15'h0, busy}, 16'h0);
    check({tag, "_err"},     {15'h0, err}, 16'h0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got simulation still running, want completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [7:0] bad_ops [3];
    bad_ops[0] = 8'h7A;
    bad_ops[1] = 8'h02;
    bad_ops[2] = 8'hFF;
    reset   = 1'b0;
    rx_data = 8'h00;
    rx_done = 1'b0;
    tx_done = 1'b0;
    for (int i = 0; i < DEPTH; i++) mem_m[i] = 16'h0000;
    tick(2);
    check_reset_outputs("rst");
    reset = 1'b1;
    tick(2);

    // Load of an untouched word right after reset; busy spans the whole exchange.
    exp_tx.push_back(8'h00);
    exp_tx.push_back(8'h00);
    send_byte(8'h00);
    check("busy_first_byte", {15'h0, busy}, 16'h1);
    send_byte(8'h1F);
    check("load_latency", {15'h0, tx_en}, 16'h1);
    check("load1f_hi", {8'h00, tx_data}, 16'h0000);
    serve_tx("load1f_hi", 2);
    check("busy_mid_resp", {15'h0, busy}, 16'h1);
    serve_tx("load1f_lo", 2);
    check("busy_after_last", {15'h0, busy}, 16'h0);
    tick(2);

    // Store then load back.
    do_store(8'h05, 16'hBEEF);
    check("store_latency", {15'h0, tx_en}, 16'h1);
    check("store_ack", {8'h00, tx_data}, 16'h0006);
    serve_tx("ack05", 3);
    do_load(8'h05);
    check("load05_hi", {8'h00, tx_data}, 16'h00BE);
    serve_tx("load05_hi", 1);
    check("load05_lo", {8'h00, tx_data}, 16'h00EF);
    serve_tx("load05_lo", 0);
    tick(1);

    // Address 0x25 wraps onto word 5.
    do_store(8'h25, 16'h1234);
    serve_tx("ack25", 1);
    do_load(8'h05);
    check("wrap_hi", {8'h00, tx_data}, 16'h0012);
    serve_tx("wrap_hi", 1);
    check("wrap_lo", {8'h00, tx_data}, 16'h0034);
    serve_tx("wrap_lo", 1);
    tick(1);

    foreach (bad_ops[k]) begin
      exp_err++;
      send_byte(bad_ops[k]);
      check("badop_err", {15'h0, err}, 16'h1);
      check("badop_busy", {15'h0, busy}, 16'h0);
      check("badop_tx_en", {15'h0, tx_en}, 16'h0);
      tick(1);
      check("badop_err_clear", {15'h0, err}, 16'h0);
    end

    // Store frame abandoned after the address byte: timeout, no write.
    exp_err++;
    send_byte(8'h01);
    send_byte(8'h03);
    tick(TO - 1);
    check("to_busy_before", {15'h0, busy}, 16'h1);
    check("to_err_before", {15'h0, err}, 16'h0);
    tick(1);
    check("to_err", {15'h0, err}, 16'h1);
    check("to_idle", {15'h0, busy}, 16'h0);
    tick(2);
    do_load(8'h03);
    check("to_nowrite_hi", {8'h00, tx_data}, 16'h0000);
    serve_tx("load03_hi", 1);
    serve_tx("load03_lo", 1);
    tick(1);

    // Timeout while waiting for the address.
    exp_err++;
    send_byte(8'h00);
    tick(TO);
    check("to_addr_err", {15'h0, err}, 16'h1);
    tick(2);

    // A byte landing in the expiry cycle is accepted.
    mem_m[7] = 16'hAA55;
    exp_tx.push_back(8'h06);
    send_byte(8'h01);
    send_byte(8'h07);
    tick(TO - 1);
    send_byte(8'hAA);
    check("edge_no_err", {15'h0, err}, 16'h0);
    send_byte(8'h55);
    check("edge_ack", {8'h00, tx_data}, 16'h0006);
    serve_tx("ack07", 1);
    do_load(8'h07);
    check("edge_hi", {8'h00, tx_data}, 16'h00AA);
    serve_tx("load07_hi", 1);
    serve_tx("load07_lo", 1);
    tick(1);

    // Bytes arriving during WAIT_HI are dropped; reset in WAIT_LO kills the response.
    do_store(8'h09, 16'hC35A);
    serve_tx("ack09", 1);
    do_load(8'h09);
    wait_tx("load09_hi");
    tick(1);
    send_byte(8'h01);
    send_byte(8'h00);
    check("busy_wait_hi", {15'h0, busy}, 16'h1);
    tx_done = 1'b1;
    tick(1);
    tx_done = 1'b0;
    check("ignored_rx_lo", {8'h00, tx_data}, 16'h005A);
    wait_tx("load09_lo");
    tick(2);
    reset = 1'b0;
    for (int i = 0; i < DEPTH; i++) mem_m[i] = 16'h0000;
    #1;
    check_reset_outputs("midrst");
    tick(2);
    reset = 1'b1;
    tick(1);
    tx_done = 1'b1;
    tick(1);
    tx_done = 1'b0;
    tick(20);
    check("post_rst_busy", {15'h0, busy}, 16'h0);
    do_load(8'h09);
    check("post_rst_cleared", {8'h00, tx_data}, 16'h0000);
    serve_tx("load09b_hi", 1);
    serve_tx("load09b_lo", 1);
    tick(3);

    check("pending_tx", 16'(exp_tx.size()), 16'h0);
    check("pending_err", 16'(exp_err), 16'h0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compares, fails);
    $finish;
  end

endmodule

// File: doc/bitty_uart_mem.md
BITTY_UART_MEM -- requirements
Module: bitty_uart_mem

Interface
REQ-001 Parameter DEPTH, default 32, number of 16-bit memory words (power of two, 2..256).
REQ-002 Parameter TIMEOUT, default 50000, max idle clock cycles between bytes of one frame.
REQ-003 clk  input  1  single clock; all state updates on rising edge.
REQ-004 reset  input  1  asynchronous, active-low reset.
REQ-005 rx_data  input  8  byte from UART receiver, valid when rx_done=1.
REQ-006 rx_done  input  1  one-cycle pulse, new byte on rx_data.
REQ-007 tx_done  input  1  one-cycle pulse, UART transmitter finished the current byte.
REQ-008 tx_en  output  1  one-cycle pulse, start transmitting tx_data.
REQ-009 tx_data  output  8  byte to transmit, held stable from tx_en until tx_done.
REQ-010 busy  output  1  high whenever FSM is not IDLE.
REQ-011 err  output  1  one-cycle pulse on bad opcode or frame timeout.

Function
REQ-012 Block SHALL be the UART-side memory responder for the CPU load/store unit; CPU is initiator, this block answers.
REQ-013 Load frame SHALL be: 0x00, addr; response SHALL be data[15:8] then data[7:0].
REQ-014 Store frame SHALL be: 0x01, addr, data[15:8], data[7:0]; response SHALL be single byte 0x06 (ACK).
REQ-015 Word index SHALL be addr[log2(DEPTH)-1:0]; higher address bits ignored (wrap-around).
REQ-016 FSM states SHALL be IDLE, GET_ADDR, GET_DH, GET_DL, SEND_HI, WAIT_HI, SEND_LO, WAIT_LO, SEND_ACK, WAIT_ACK.
REQ-017 IDLE: rx_done with 0x00 or 0x01 -> GET_ADDR, opcode latched; any other byte -> stay IDLE, err pulse.
REQ-018 GET_ADDR: rx_done -> address latched; load -> SEND_HI; store -> GET_DH.
REQ-019 GET_DH: rx_done -> high byte latched, GET_DL; GET_DL: rx_done -> memory written in same edge, SEND_ACK.
REQ-020 SEND_x states SHALL drive tx_en=1 for exactly one cycle with tx_data set, then go to matching WAIT_x.
REQ-021 WAIT_HI + tx_done -> SEND_LO; WAIT_LO + tx_done -> IDLE; WAIT_ACK + tx_done -> IDLE.
REQ-022 Load data SHALL be sampled from memory when leaving GET_ADDR; tx_data in SEND_LO uses that same sample.
REQ-023 Latency: first tx_en SHALL occur 1 cycle after the rx_done carrying addr (load) or data[7:0] (store).
REQ-024 rx_done in any SEND/WAIT state SHALL be ignored; no queuing.
REQ-025 tx_done outside WAIT states SHALL be ignored.
REQ-026 Timeout counter SHALL clear on every accepted byte; in GET_ADDR/GET_DH/GET_DL reaching TIMEOUT cycles -> IDLE, err pulse, no write.
REQ-027 rx_done in the same cycle as timeout expiry SHALL be accepted; no timeout taken.
REQ-028 WAIT states SHALL have no timeout.

Reset
REQ-029 Reset low SHALL force IDLE, tx_en=0, tx_data=0x00, busy=0, err=0, timeout counter=0, all memory words=0x0000.
REQ-030 Reset mid-frame or mid-response SHALL abort with no memory write and no further tx_en.

Structure
REQ-031 Shared package SHALL hold the state enum, opcodes OP_LOAD=0x00, OP_STORE=0x01, ACK byte 0x06.
REQ-032 Memory array MAY be one sub-module bitty_word_mem (1 write port, 1 async read port, reset-clear).

Verification
REQ-033 Store 0x01,0x05,0xBE,0xEF -> one tx_en with tx_data=0x06; then load 0x00,0x05 -> tx 0xBE then 0xEF.
REQ-034 After reset, load 0x00,0x1F -> tx 0x00, 0x00; busy high from first byte until last tx_done.
REQ-035 Store 0x01,0x25,0x12,0x34 with DEPTH=32 -> load 0x00,0x05 returns 0x12,0x34 (wrap).
REQ-036 Byte 0x7A in IDLE -> err pulse, no tx_en, busy stays 0.
REQ-037 Send 0x01,0x03 then silence TIMEOUT cycles -> err pulse, IDLE; load 0x00,0x03 returns 0x00,0x00.
REQ-038 rx_done pulses during WAIT_HI -> ignored, response bytes unchanged; reset asserted in WAIT_LO -> no tx_en follows.
